// File: rtl/axil_ptgen_pkg.sv
// Shared types and constants for the AXI4-Lite pattern generator master.
// Build option: PTGEN_LFSR_EN selects the LFSR pattern source (see axil_ptgen_pattern).
package axil_ptgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int data_w);
    return (data_w == 64) ? LFSR_TAPS_64 : {32'h0, LFSR_TAPS_32};
  endfunction

endpackage

// File: rtl/axil_ptgen_if.sv
// AXI4-Lite bus between the pattern generator master and its slave.
// No build options.
interface axil_ptgen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ptgen_pattern.sv
// Pattern word register: load restarts from SEED, step advances one beat.
// Build option: PTGEN_LFSR_EN selects a Galois LFSR instead of an incrementer.
module axil_ptgen_pattern
  import axil_ptgen_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] pattern_reg;
  logic [DATA_W-1:0] pattern_next;

`ifdef PTGEN_LFSR_EN
  localparam logic [63:0]       TAPS_FULL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];

  // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
  always_comb begin
    pattern_next = pattern_reg >> 1;
    if (pattern_reg[0]) begin
      pattern_next = (pattern_reg >> 1) ^ TAPS;
    end
  end
`else
  always_comb begin
    pattern_next = pattern_reg + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg <= SEED;
    end else if (load) begin
      pattern_reg <= SEED;
    end else if (step) begin
      pattern_reg <= pattern_next;
    end
  end

  assign pattern = pattern_reg;

endmodule

// File: rtl/axil_ptgen_master.sv
// AXI4-Lite master: writes NUM_TXN pattern words from BASE_ADDR, reads them back and checks.
// Build option: PTGEN_LFSR_EN (LFSR pattern instead of SEED + i).
module axil_ptgen_master
  import axil_ptgen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_TXN   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(1),
  parameter int                ERRCNT_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                INIT_AXI_TXN,
  output logic                TXN_DONE,
  output logic                ERROR,
  output logic [ERRCNT_W-1:0] ERR_COUNT,
  axil_ptgen_if.master        m_axi
);

  localparam int                IDX_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TXN - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);

  state_t              state_reg;
  logic                init_reg, init_prev_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                issue_reg, aw_done_reg, w_done_reg;
  logic                awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
  logic [ADDR_W-1:0]   awaddr_reg, araddr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                txn_done_reg, error_reg;
  logic [ERRCNT_W-1:0] err_count_reg;

  logic [DATA_W-1:0]   pattern;
  logic [ADDR_W-1:0]   beat_addr;
  logic                start_ok, is_last;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, r_fail;
  logic                pat_load, pat_step;

  assign start_ok  = init_reg && !init_prev_reg && (state_reg == IDLE || state_reg == DONE);
  assign is_last   = (idx_reg == LAST_IDX);
  assign beat_addr = BASE_ADDR + ADDR_W'(idx_reg) * STRIDE;

  assign aw_hs  = awvalid_reg && m_axi.awready;
  assign w_hs   = wvalid_reg && m_axi.wready;
  assign b_hs   = bready_reg && m_axi.bvalid;
  assign ar_hs  = arvalid_reg && m_axi.arready;
  assign r_hs   = rready_reg && m_axi.rvalid;
  assign r_fail = (m_axi.rresp != RESP_OKAY) || (m_axi.rdata != pattern);

  // Pattern control mirrors the FSM's index moves so pattern always equals pattern(idx).
  assign pat_load = start_ok || (state_reg == WRITE && b_hs && is_last);
  assign pat_step = !start_ok && (((state_reg == WRITE) && b_hs && !is_last) ||
                                  ((state_reg == READ) && r_hs && !is_last));

  axil_ptgen_pattern #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk     (ACLK),
    .rst     (ARESET),
    .load    (pat_load),
    .step    (pat_step),
    .pattern (pattern)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= IDLE;
      init_reg      <= 1'b0;
      init_prev_reg <= 1'b0;
      idx_reg       <= '0;
      issue_reg     <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awaddr_reg    <= BASE_ADDR;
      araddr_reg    <= BASE_ADDR;
      wdata_reg     <= '0;
      txn_done_reg  <= 1'b0;
      error_reg     <= 1'b0;
      err_count_reg <= '0;
    end else begin
      init_reg      <= INIT_AXI_TXN;
      init_prev_reg <= init_reg;

      if (start_ok) begin
        // First beat goes out straight from the start edge, bypassing the issue cycle.
        state_reg     <= WRITE;
        idx_reg       <= '0;
        issue_reg     <= 1'b0;
        aw_done_reg   <= 1'b0;
        w_done_reg    <= 1'b0;
        awvalid_reg   <= 1'b1;
        wvalid_reg    <= 1'b1;
        awaddr_reg    <= BASE_ADDR;
        wdata_reg     <= SEED;
        txn_done_reg  <= 1'b0;
        error_reg     <= 1'b0;
        err_count_reg <= '0;
      end else begin
        case (state_reg)
          WRITE: begin
            if (issue_reg) begin
              issue_reg   <= 1'b0;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              awaddr_reg  <= beat_addr;
              wdata_reg   <= pattern;
            end else begin
              if (aw_hs) begin
                awvalid_reg <= 1'b0;
                aw_done_reg <= 1'b1;
              end
              if (w_hs) begin
                wvalid_reg <= 1'b0;
                w_done_reg <= 1'b1;
              end
              if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs) && !bready_reg) begin
                bready_reg <= 1'b1;
              end
              if (b_hs) begin
                bready_reg  <= 1'b0;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
                issue_reg   <= 1'b1;
                if (m_axi.bresp != RESP_OKAY) begin
                  error_reg <= 1'b1;
                  if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
                end
                if (is_last) begin
                  idx_reg   <= '0;
                  state_reg <= READ;
                end else begin
                  idx_reg <= idx_reg + 1'b1;
                end
              end
            end
          end

          READ: begin
            if (issue_reg) begin
              issue_reg   <= 1'b0;
              arvalid_reg <= 1'b1;
              araddr_reg  <= beat_addr;
            end else begin
              if (ar_hs) begin
                arvalid_reg <= 1'b0;
                rready_reg  <= 1'b1;
              end
              if (r_hs) begin
                rready_reg <= 1'b0;
                if (r_fail) begin
                  error_reg <= 1'b1;
                  if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
                end
                if (is_last) begin
                  state_reg    <= DONE;
                  txn_done_reg <= 1'b1;
                end else begin
                  idx_reg   <= idx_reg + 1'b1;
                  issue_reg <= 1'b1;
                end
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign m_axi.awaddr  = awaddr_reg;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = araddr_reg;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

  assign TXN_DONE  = txn_done_reg;
  assign ERROR     = error_reg;
  assign ERR_COUNT = err_count_reg;

endmodule

// File: doc/axil_ptgen_master.md
# axil_ptgen_master

Parametrised AXI4-Lite master pattern generator for the custom-IP example designs. On a start pulse it writes NUM_TXN pattern words to consecutive addresses from BASE_ADDR, reads them back, and compares each read against the regenerated pattern. It reports completion, a sticky error flag and a saturating mismatch count. It replaces the fixed-width single-error-bit master used in the IP test benches, sitting in the block design opposite an AXI VIP slave or a real slave.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only
- NUM_TXN, 4, words per run; 1..256
- BASE_ADDR, 32'h4000_0000, first target address
- SEED, 1, pattern start value; must be nonzero when LFSR mode is compiled in
- ERRCNT_W, 8, mismatch counter width

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- INIT_AXI_TXN  in  1  start request; rising edge starts a run
- TXN_DONE  out  1  high in DONE until the next accepted start
- ERROR  out  1  sticky; set on any mismatch or non-OKAY response
- ERR_COUNT  out  ERRCNT_W  saturating count of failed beats
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR_W/3/1/1  write address; AWPROT=3'b000
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/DATA_W/8/1/1  write data; WSTRB all ones
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR_W/3/1/1  read address; ARPROT=3'b000
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_W/2/1/1  read data

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- Start: INIT_AXI_TXN is registered. A start is accepted on a 0->1 edge only in IDLE or DONE. Acceptance clears ERROR, ERR_COUNT, TXN_DONE and the beat index, reloads the pattern from SEED, and enters WRITE. Edges seen in WRITE or READ are ignored.
- Beat i (0..NUM_TXN-1): address = BASE_ADDR + i*(DATA_W/8), truncated to ADDR_W, so it wraps modulo 2^ADDR_W. Data = pattern(i). Default pattern(i) = SEED + i, mod 2^DATA_W.
- WRITE: one beat outstanding at a time.
  - AWVALID and WVALID rise together. Each drops independently on its own handshake.
  - BREADY is high while a response is pending.
  - On the B handshake: BRESP != OKAY sets ERROR and increments ERR_COUNT; the index advances.
  - After the last B handshake: index and pattern reset, enter READ.
- READ: ARVALID is held until the AR handshake. RREADY is high while the response is pending.
  - On the R handshake the beat fails if RRESP != OKAY or RDATA != pattern(i). A failed beat sets ERROR and increments ERR_COUNT once.
  - After the last R handshake, enter DONE.
- DONE: TXN_DONE=1. ERROR and ERR_COUNT hold.
- ERR_COUNT saturates at all ones.

## Timing
- Reset values: all VALID/READY outputs 0, AWADDR/ARADDR = BASE_ADDR, WDATA 0, TXN_DONE 0, ERROR 0, ERR_COUNT 0, state IDLE.
- The first AWVALID/WVALID is asserted 2 cycles after INIT_AXI_TXN rises (edge register, then FSM).
- Once asserted, VALID never drops before its handshake. Address and data stay stable while VALID is high.
- The next beat's AWVALID is asserted the cycle after the B handshake; ARVALID likewise after the R handshake.
- Best case with zero-wait slave: 3 cycles per write beat, 3 cycles per read beat.
- TXN_DONE rises the cycle after the final R handshake.
- AWREADY and WREADY may arrive in either order or together; the beat waits for both handshakes before BREADY matters.
- ARESET mid-run drops all VALIDs immediately (asynchronous) and returns to IDLE. This is the only permitted VALID drop.

## Configuration
- PTGEN_LFSR_EN defined: pattern is a Galois LFSR over DATA_W, starting at SEED and stepped once per beat, using the tap mask from the package. The read phase restarts the LFSR from SEED.
- PTGEN_LFSR_EN undefined: incrementing pattern SEED + i. No LFSR logic is present.

## Structure
- Package axil_ptgen_pkg holds:
  - state enum
  - AXI response constants (OKAY=2'b00, SLVERR=2'b10)
  - LFSR tap masks: 32'h8020_0003 for DATA_W=32, 64'hD800_0000_0000_0000 for DATA_W=64
- Sub-module axil_ptgen_pattern: holds the pattern register, with load-from-SEED and step inputs. Increment vs LFSR is selected by the macro.

## Test plan
- NUM_TXN=4, BASE 0x4000_0000, SEED=1, zero-wait memory slave -> AWADDR 0x4000_0000/04/08/0C, WDATA 1..4; TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- Slave corrupts read beat 2 (returns 0) -> ERROR=1, ERR_COUNT=1, TXN_DONE=1.
- BRESP=SLVERR on beat 0, and RRESP=SLVERR with matching data on beat 3 -> ERR_COUNT=2.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles with a stable address, and one B is accepted per beat.
- Second INIT pulse during READ is ignored. A new INIT in DONE clears ERROR/ERR_COUNT and reruns, with identical AWADDR/WDATA.
- ARESET asserted while AWVALID=1 -> AWVALID=0 in the same cycle, state IDLE, TXN_DONE=0. With PTGEN_LFSR_EN defined, DATA_W=32, SEED=1: beat 1 WDATA = 32'h8020_0003.
